oddr_serializer: RTL and testbench

Parametrised DDR output serializer, generic logic only. It accepts one wide parallel word per transfer through a valid/ready handshake and shifts it out on WIDTH lanes, two beats per clock cycle, over RATIO cycles. Beats go out on the rising and falling phases of `clk`. It sits between framing logic in the `clk` domain and the output pins of source-synchronous interfaces (RGMII-style, SPI-DDR, custom links). It generalises a single-beat output DDR flop with lane count, serialization ratio, flow control, an idle pattern and frame marking.

---
 rtl/oddr_serializer.sv | 79 +++++++
 tb/tb_oddr_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oddr_serializer.sv
// DDR output serializer: takes one parallel word per valid/ready transfer and
// shifts it out on WIDTH lanes, an even beat in the high phase and an odd beat in the low phase.
module oddr_serializer #(
  parameter int               WIDTH      = 1,
  parameter int               RATIO      = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH*2*RATIO-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [WIDTH-1:0]         q,
  output logic                     q_frame,
  output logic                     busy
);
  localparam int DW = WIDTH * 2 * RATIO;
  localparam int CW = $clog2(RATIO + 1);

  logic [DW-1:0]    sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] stg_q, stg_d;
  logic [WIDTH-1:0] fall_q;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             take;

  // Ready depends only on registered state, so a word can land as the last pair leaves.
  assign s_ready = !rst && (cnt_q <= CW'(1));
  assign take    = s_valid && s_ready;

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    rise_d  = IDLE_VALUE;
    stg_d   = IDLE_VALUE;
    frame_d = 1'b0;
    busy_d  = (cnt_q != '0);
    if (cnt_q != '0) begin
      rise_d  = sh_q[WIDTH-1:0];
      stg_d   = sh_q[2*WIDTH-1:WIDTH];
      frame_d = (cnt_q == CW'(RATIO));
      sh_d    = sh_q >> (2 * WIDTH);
      cnt_d   = cnt_q - 1'b1;
    end
    if (take) begin
      sh_d  = s_data;
      cnt_d = CW'(RATIO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      rise_q  <= IDLE_VALUE;
      stg_q   <= IDLE_VALUE;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      stg_q   <= stg_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  // Odd beat staged at the rising edge moves to the low-phase register at the falling edge.
  always_ff @(negedge clk) begin
    fall_q <= stg_q;
  end

  assign q       = clk ? rise_q : fall_q;
  assign q_frame = frame_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_oddr_serializer.sv
// Scoreboard bench for oddr_serializer: three configurations share clock and reset,
// the driver queues accepted words and a monitor checks both phases of every cycle.
module tb_oddr_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      sv, rdy, fr_o, bz_o;
  logic [2:0][7:0] sd;
  logic [2:0][3:0] qv;
  logic [1:0]      qA;
  logic [0:0]      qB;
  logic [3:0]      qC;

  assign qv[0] = {2'b00, qA};
  assign qv[1] = {3'b000, qB};
  assign qv[2] = qC;

  oddr_serializer #(.WIDTH(2), .RATIO(2), .IDLE_VALUE(2'b01)) uA (
    .clk(clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(rdy[0]),
    .q(qA), .q_frame(fr_o[0]), .busy(bz_o[0]));
  oddr_serializer #(.WIDTH(1), .RATIO(4), .IDLE_VALUE(1'b0)) uB (
    .clk(clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(rdy[1]),
    .q(qB), .q_frame(fr_o[1]), .busy(bz_o[1]));
  oddr_serializer #(.WIDTH(4), .RATIO(1), .IDLE_VALUE(4'h3)) uC (
    .clk(clk), .rst(rst), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(rdy[2]),
    .q(qC), .q_frame(fr_o[2]), .busy(bz_o[2]));

  int         W   [3] = '{2, 1, 4};
  int         R   [3] = '{2, 4, 1};
  logic [3:0] IDL [3] = '{4'h1, 4'h0, 4'h3};

  typedef struct {
    logic [7:0] w;
    int         gap;
    int         acc;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  int nvec = 0, nerr = 0, cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[inst %0d] @cyc %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // beat b of lane group sits at bit b*width
  function automatic int beat(input logic [7:0] w, input int wd, input int b);
    return (int'(w) >> (b * wd)) & ((1 << wd) - 1);
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] hi_s [3];
  logic       bz_s [3], fr_s [3];
  logic [7:0] cur  [3];
  int         idx  [3];
  bit         act  [3];
  int         gapc [3];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      hi_s[i] = qv[i];
      bz_s[i] = bz_o[i];
      fr_s[i] = fr_o[i];
    end
  end

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        bit   efr;
        if (bz_s[i]) begin
          efr = !act[i] || (idx[i] >= 2 * R[i]);
          chk("q_frame", i, int'(fr_s[i]), int'(efr));
          if (fr_s[i]) begin
            if (qsize(i) == 0) chk("word_queued", i, 0, 1);
            else begin
              e = pop(i);
              cur[i] = e.w;
              idx[i] = 0;
              act[i] = 1'b1;
              if (e.gap >= 0) chk("idle_gap", i, gapc[i], e.gap);
              chk("latency", i, cyc - e.acc, 1);
            end
          end
          if (act[i] && idx[i] < 2 * R[i]) begin
            chk("q_high", i, int'(hi_s[i]), beat(cur[i], W[i], idx[i]));
            chk("q_low", i, int'(qv[i]), beat(cur[i], W[i], idx[i] + 1));
            idx[i] += 2;
          end
          gapc[i] = 0;
        end else begin
          chk("idle_high", i, int'(hi_s[i]), int'(IDL[i]));
          chk("idle_low", i, int'(qv[i]), int'(IDL[i]));
          chk("frame_idle", i, int'(fr_s[i]), 0);
          act[i] = 1'b0;
          gapc[i]++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int i, input logic [7:0] w, input int gap, input bit keep,
                      output int acc);
    bit   ok = 1'b0;
    int   n  = 0;
    exp_t e;
    acc   = 0;
    sd[i] = w;
    sv[i] = 1'b1;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = rdy[i] && !rst;
      @(posedge clk);
      n++;
    end
    #1;
    if (!ok) chk("handshake_timeout", i, 0, 1);
    else begin
      acc   = cyc;
      e.w   = w;
      e.gap = gap;
      e.acc = cyc;
      push(i, e);
    end
    #1;
    if (!keep) sv[i] = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    rst = 1'b1;
    sv  = '0;
    sd  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("ready_after_init", 0, int'(rdy[0]), 1);
    #1;

    // single word: beats 00,01 then 10,11
    send(0, 8'hE4, -1, 1'b0, a0);
    repeat (4) @(posedge clk);
    #2;

    // reset held 3 cycles in the middle of a word
    send(0, 8'h1B, -1, 1'b0, a0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #2;
      chk("ready_in_rst", 0, int'(rdy[0]), 0);
      chk("busy_in_rst", 0, int'(bz_o[0]), 0);
      chk("q_low_in_rst", 0, int'(qv[0]), 1);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 0, int'(rdy[0]), 1);
    @(posedge clk);
    #2;
    send(0, 8'h2D, -1, 1'b0, a0);
    repeat (4) @(posedge clk);
    #2;

    // back-to-back with valid held high
    send(1, 8'h96, -1, 1'b1, a0);
    send(1, 8'h3C, 0, 1'b1, a1);
    chk("ready_spacing", 1, a1 - a0, 4);
    send(1, 8'hF0, 0, 1'b0, a2);
    chk("ready_spacing", 1, a2 - a1, 4);

    // valid withheld over two ready edges, then one more word
    repeat (5) @(posedge clk);
    #2;
    send(1, 8'h7E, 2, 1'b0, a3);
    chk("gap_handshake", 1, a3 - a2, 6);
    repeat (6) @(posedge clk);
    #2;

    // reset after the first of four pairs
    send(1, 8'h5A, -1, 1'b0, a0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 1, int'(rdy[1]), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    send(1, 8'hC3, -1, 1'b0, a0);
    repeat (6) @(posedge clk);
    #2;

    // RATIO=1 streaming: 5 high / A low every cycle
    send(2, 8'hA5, -1, 1'b1, a0);
    for (int k = 0; k < 5; k++) begin
      send(2, 8'hA5, 0, (k < 4), a1);
      chk("ready_every_cycle", 2, a1 - a0, 1);
      a0 = a1;
    end
    repeat (4) @(posedge clk);
    #2;

    chk("queue_empty", 0, q0.size(), 0);
    chk("queue_empty", 1, q1.size(), 0);
    chk("queue_empty", 2, q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
